// File: rtl/lcd_scanline_fx.sv
// Video post-processing stage: optional 2-tap horizontal blend followed by scanline
// darkening on every fourth line, with a fixed two-ce pipeline and delayed syncs.
module lcd_scanline_fx (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       blank_in,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic [1:0] sl_mode,
  input  logic       blend_en,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  logic [9:0] line_cnt;
  logic       vs_prev;
  logic       hs_prev;
  logic [1:0] sl_mode_sh;
  logic       blend_sh;
  logic       prev_valid;
  logic [7:0] prev_r, prev_g, prev_b;

  logic       hs1, vs1, blank1;
  logic [7:0] s1_r, s1_g, s1_b;

  logic       use_blend;
  logic       dark;
  logic       vs_rise;
  logic       hs_rise;

  // Rounded average; the 9-bit sum keeps the carry before the halving shift.
  function automatic logic [7:0] blend_px(input logic [7:0] cur, input logic [7:0] prv);
    logic [8:0] sum;
    sum = {1'b0, cur} + {1'b0, prv} + 9'd1;
    return sum[8:1];
  endfunction

  function automatic logic [7:0] darken_px(input logic [7:0] s, input logic [1:0] mode);
    logic [7:0] y;
    case (mode)
      2'd1:    y = s - (s >> 2);
      2'd2:    y = s >> 1;
      2'd3:    y = s >> 2;
      default: y = s;
    endcase
    return y;
  endfunction

  assign use_blend = blend_sh && prev_valid;
  assign vs_rise   = vs_in && !vs_prev;
  assign hs_rise   = hs_in && !hs_prev;
  // line_cnt and the shadow mode already belong to the pixel held in stage 1.
  assign dark      = (sl_mode_sh != 2'd0) && (line_cnt[1:0] == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt   <= '0;
      vs_prev    <= 1'b0;
      hs_prev    <= 1'b0;
      sl_mode_sh <= '0;
      blend_sh   <= 1'b0;
      prev_valid <= 1'b0;
      prev_r     <= '0;
      prev_g     <= '0;
      prev_b     <= '0;
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      blank1     <= 1'b1;
      s1_r       <= '0;
      s1_g       <= '0;
      s1_b       <= '0;
      hs         <= 1'b0;
      vs         <= 1'b0;
      blank      <= 1'b1;
      r          <= '0;
      g          <= '0;
      b          <= '0;
    end else if (ce) begin
      vs_prev <= vs_in;
      hs_prev <= hs_in;
      // Effect settings are only sampled at frame start so a frame never tears.
      if (vs_rise) begin
        line_cnt   <= '0;
        sl_mode_sh <= sl_mode;
        blend_sh   <= blend_en;
      end else if (hs_rise) begin
        line_cnt <= line_cnt + 10'd1;
      end

      if (!blank_in) begin
        prev_r     <= r_in;
        prev_g     <= g_in;
        prev_b     <= b_in;
        prev_valid <= 1'b1;
      end else begin
        prev_valid <= 1'b0;
      end

      hs1    <= hs_in;
      vs1    <= vs_in;
      blank1 <= blank_in;
      s1_r   <= use_blend ? blend_px(r_in, prev_r) : r_in;
      s1_g   <= use_blend ? blend_px(g_in, prev_g) : g_in;
      s1_b   <= use_blend ? blend_px(b_in, prev_b) : b_in;

      hs    <= hs1;
      vs    <= vs1;
      blank <= blank1;
      if (blank1) begin
        r <= '0;
        g <= '0;
        b <= '0;
      end else if (dark) begin
        r <= darken_px(s1_r, sl_mode_sh);
        g <= darken_px(s1_g, sl_mode_sh);
        b <= darken_px(s1_b, sl_mode_sh);
      end else begin
        r <= s1_r;
        g <= s1_g;
        b <= s1_b;
      end
    end
  end

endmodule

// File: tb/tb_lcd_scanline_fx.sv
// Self-checking bench for lcd_scanline_fx: randomized video frames compared each cycle
// against a frame/line-level reference model, plus a few fixed-value scenarios.
module tb_lcd_scanline_fx;

  logic       clk = 1'b0;
  logic       reset, ce, hs_in, vs_in, blank_in, blend_en;
  logic [7:0] r_in, g_in, b_in;
  logic [1:0] sl_mode;
  logic       hs, vs, blank;
  logic [7:0] r, g, b;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  pix_t pipe[$];
  int   mPrev[3];
  bit   mPrevValid, mVsPrev, mHsPrev, mBlend;
  int   mLine, mMode;
  int   curMode;
  bit   curBlend;
  int   obs[$];

  lcd_scanline_fx dut (
    .clk(clk), .reset(reset), .ce(ce), .hs_in(hs_in), .vs_in(vs_in),
    .blank_in(blank_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .sl_mode(sl_mode), .blend_en(blend_en),
    .hs(hs), .vs(vs), .blank(blank), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  function automatic pix_t blankPix();
    pix_t p;
    p = '0;
    p.blank = 1'b1;
    return p;
  endfunction

  function automatic void modelReset();
    pipe = {blankPix(), blankPix()};
    mPrevValid = 0;
    mVsPrev = 0;
    mHsPrev = 0;
    mBlend = 0;
    mLine = 0;
    mMode = 0;
  endfunction

  function automatic int darkenRef(int s, int mode);
    case (mode)
      1: return s - s / 4;
      2: return s / 2;
      3: return s / 4;
      default: return s;
    endcase
  endfunction

  // One ce step of the reference: each input pixel's final value is computed at once
  // and then simply waits two ce steps in the queue.
  function automatic void modelStep();
    int   x[3];
    int   s[3];
    pix_t o;
    x = '{int'(r_in), int'(g_in), int'(b_in)};
    for (int i = 0; i < 3; i++)
      s[i] = (mBlend && mPrevValid) ? (x[i] + mPrev[i] + 1) / 2 : x[i];
    if (!blank_in) begin
      mPrev = x;
      mPrevValid = 1;
    end else begin
      mPrevValid = 0;
    end
    if (vs_in && !mVsPrev) begin
      mLine = 0;
      mMode = int'(sl_mode);
      mBlend = blend_en;
    end else if (hs_in && !mHsPrev) begin
      mLine = (mLine + 1) % 1024;
    end
    mVsPrev = vs_in;
    mHsPrev = hs_in;
    for (int i = 0; i < 3; i++) begin
      if (mMode != 0 && mLine % 4 == 3) s[i] = darkenRef(s[i], mMode);
      if (blank_in) s[i] = 0;
    end
    o.hs = hs_in;
    o.vs = vs_in;
    o.blank = blank_in;
    o.r = 8'(s[0]);
    o.g = 8'(s[1]);
    o.b = 8'(s[2]);
    pipe.push_back(o);
    void'(pipe.pop_front());
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one clock cycle, advances the model, and compares the whole output bundle.
  task automatic applyStimulus(input bit rst, input bit c, input bit h, input bit v,
                               input bit bl, input logic [7:0] rr, input logic [7:0] gg,
                               input logic [7:0] bb);
    reset = rst;
    ce = c;
    hs_in = h;
    vs_in = v;
    blank_in = bl;
    r_in = rr;
    g_in = gg;
    b_in = bb;
    sl_mode = 2'(curMode);
    blend_en = curBlend;
    @(posedge clk);
    if (rst) modelReset();
    else if (c) modelStep();
    #1;
    checkOutput("pipe", 32'({hs, vs, blank, r, g, b}), 32'(pipe[0]));
    obs.push_back(int'(r));
  endtask

  task automatic pixel(input bit h, input bit v, input bit bl, input logic [7:0] rr,
                       input logic [7:0] gg, input logic [7:0] bb);
    if ($urandom_range(0, 3) == 0)
      applyStimulus(0, 0, 1'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom));
    if ($urandom_range(0, 40) == 0) curMode = $urandom_range(0, 3);
    if ($urandom_range(0, 40) == 0) curBlend = 1'($urandom);
    applyStimulus(0, 1, h, v, bl, rr, gg, bb);
  endtask

  task automatic randLine(input int n, input bit v);
    pixel(1, v, 1, 8'($urandom), 8'($urandom), 8'($urandom));
    pixel(1, v, 1, 8'($urandom), 8'($urandom), 8'($urandom));
    pixel(0, v, 1, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < n; i++)
      pixel(0, v, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    pixel(0, v, 1, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic randFrame(input int lines, input int n, input bit midReset);
    for (int l = 0; l < lines; l++) begin
      randLine(n, l < 2);
      if (midReset && l == lines / 2)
        applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    int base;
    curMode = 0;
    curBlend = 0;
    modelReset();

    // Reset with ce high and random inputs, then with ce low.
    applyStimulus(1, 1, 1, 1, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    checkOutput("reset_ce1", 32'({hs, vs, blank, r, g, b}), 32'h100_0000);
    applyStimulus(1, 0, 1, 1, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    checkOutput("reset_ce0", 32'({hs, vs, blank, r, g, b}), 32'h100_0000);

    // Blend latched at vs: 0x10,0x21,0xFF -> 0x10,0x19,0x90; next line starts unblended.
    curBlend = 1;
    applyStimulus(0, 1, 1, 1, 1, 8'h00, 8'h00, 8'h00);
    applyStimulus(0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    obs.delete();
    applyStimulus(0, 1, 0, 0, 0, 8'h10, 8'h00, 8'h00);
    applyStimulus(0, 1, 0, 0, 0, 8'h21, 8'h00, 8'h00);
    applyStimulus(0, 1, 0, 0, 0, 8'hFF, 8'h00, 8'h00);
    applyStimulus(0, 1, 0, 0, 1, 8'hFF, 8'h00, 8'h00);
    applyStimulus(0, 1, 1, 0, 1, 8'h00, 8'h00, 8'h00);
    applyStimulus(0, 1, 0, 0, 0, 8'h40, 8'h00, 8'h00);
    applyStimulus(0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    checkOutput("blend_p0", 32'(obs[1]), 32'h10);
    checkOutput("blend_p1", 32'(obs[2]), 32'h19);
    checkOutput("blend_p2", 32'(obs[3]), 32'h90);
    checkOutput("blend_first", 32'(obs[6]), 32'h40);

    // Scanline mode 2 on 0xC8 across 8 lines: every line with index 3 mod 4 is halved.
    curBlend = 0;
    curMode = 2;
    for (int l = 0; l < 8; l++) begin
      applyStimulus(0, 1, 1, l == 0, 1, 8'h00, 8'h00, 8'h00);
      base = obs.size();
      applyStimulus(0, 1, 0, 0, 0, 8'hC8, 8'hC8, 8'hC8);
      applyStimulus(0, 1, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF);
      checkOutput($sformatf("scan_l%0d", l), 32'(obs[base + 1]),
                  (l % 4 == 3) ? 32'h64 : 32'hC8);
    end

    // Randomized frames with ce gaps, mid-frame setting changes and mid-frame resets.
    for (int f = 0; f < 8; f++) begin
      curMode = $urandom_range(0, 3);
      curBlend = 1'($urandom);
      randFrame(10, $urandom_range(1, 6), f % 3 == 2);
    end
    // A long frame of short lines makes the line counter wrap past 1023.
    curMode = 3;
    randFrame(1030, 1, 0);
    randFrame(6, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
